// File: rtl/imm_pkg.sv
// Shared definitions for the registered immediate-generation stage:
// instruction-type codes and the skid-buffer FSM state encoding.
package imm_pkg;

   localparam logic [2:0] I_TYPE    = 3'b000;
   localparam logic [2:0] ISH_TYPE  = 3'b001;
   localparam logic [2:0] S_TYPE    = 3'b010;
   localparam logic [2:0] B_TYPE    = 3'b011;
   localparam logic [2:0] J_TYPE    = 3'b100;
   localparam logic [2:0] U_TYPE    = 3'b101;
   localparam logic [2:0] Z_TYPE    = 3'b110;
   localparam logic [2:0] RSVD_TYPE = 3'b111;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate decode from instr[31:7].
// IMM_GEN_ZIMM_EN enables the CSR zero-extended immediate for type 110.
module imm_decode
   import imm_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = 5
)
(
   input  logic [24:0]     i_datain,
   input  logic [2:0]      i_ins_type,
   output logic [XLEN-1:0] o_imm,
   output logic            o_illegal
);

   if (!((XLEN == 32 && SHAMT_W == 5) || (XLEN == 64 && SHAMT_W == 6))) begin : g_param_check
      $error("imm_decode: XLEN/SHAMT_W must be 32/5 or 64/6");
   end

   logic signed [11:0] w_i12;
   logic signed [11:0] w_s12;
   logic signed [12:0] w_b13;
   logic signed [20:0] w_j21;
   logic signed [31:0] w_u32;

   assign w_i12 = i_datain[24:13];
   assign w_s12 = {i_datain[24:18], i_datain[4:0]};
   assign w_b13 = {i_datain[24], i_datain[0], i_datain[23:18], i_datain[4:1], 1'b0};
   assign w_j21 = {i_datain[24], i_datain[12:5], i_datain[13], i_datain[23:14], 1'b0};
   assign w_u32 = {i_datain[24:5], 12'b0};

   // Signed size casts sign-extend; the shift amount is deliberately zero-extended.
   always_comb begin
      o_imm     = '0;
      o_illegal = 1'b0;
      case (i_ins_type)
         I_TYPE:   o_imm = XLEN'(w_i12);
         ISH_TYPE: o_imm = XLEN'(i_datain[SHAMT_W+12:13]);
         S_TYPE:   o_imm = XLEN'(w_s12);
         B_TYPE:   o_imm = XLEN'(w_b13);
         J_TYPE:   o_imm = XLEN'(w_j21);
         U_TYPE:   o_imm = XLEN'(w_u32);
`ifdef IMM_GEN_ZIMM_EN
         Z_TYPE:   o_imm = XLEN'(i_datain[12:8]);
`endif
         default:  o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate/target generation stage with valid/ready on both sides
// and a one-entry skid buffer. IMM_GEN_ZIMM_EN enables the CSR immediate type.
module imm_gen_stage
   import imm_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = 5
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [24:0]     datain,
   input  logic [2:0]      ins_type,
   input  logic [XLEN-1:0] pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] imm,
   output logic [XLEN-1:0] target,
   output logic [XLEN-1:0] doutm4,
   output logic            illegal
);

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] target;
      logic [XLEN-1:0] doutm4;
      logic            illegal;
   } entry_t;

   state_t          r_state;
   state_t          w_state_nxt;
   entry_t          r_main;
   entry_t          r_skid;
   entry_t          w_entry;
   logic [XLEN-1:0] w_imm;
   logic            w_illegal;
   logic            w_accept;
   logic            w_fire;
   logic            w_load_main;
   logic            w_load_skid;
   logic            w_main_from_skid;

   imm_decode #(
      .XLEN    (XLEN),
      .SHAMT_W (SHAMT_W)
   ) u_decode (
      .i_datain   (datain),
      .i_ins_type (ins_type),
      .o_imm      (w_imm),
      .o_illegal  (w_illegal)
   );

   assign w_entry.imm     = w_imm;
   assign w_entry.target  = pc + w_imm;
   assign w_entry.doutm4  = w_imm - XLEN'(4);
   assign w_entry.illegal = w_illegal;

   // Both handshakes are decoded from the state register only.
   assign in_ready  = (r_state != ST_FULL);
   assign out_valid = (r_state != ST_EMPTY);
   assign w_accept  = in_valid & in_ready;
   assign w_fire    = out_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_EMPTY;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_load_main      = 1'b0;
      w_load_skid      = 1'b0;
      w_main_from_skid = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_accept) begin
               w_state_nxt = ST_ONE;
               w_load_main = 1'b1;
            end
         end
         ST_ONE: begin
            if (w_accept && w_fire) begin
               w_load_main = 1'b1;
            end else if (w_accept) begin
               w_state_nxt = ST_FULL;
               w_load_skid = 1'b1;
            end else if (w_fire) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (w_fire) begin
               w_state_nxt      = ST_ONE;
               w_main_from_skid = 1'b1;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
      // A flush drops everything held plus anything accepted this cycle.
      if (flush) begin
         w_state_nxt      = ST_EMPTY;
         w_load_main      = 1'b0;
         w_load_skid      = 1'b0;
         w_main_from_skid = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_main <= '0;
         r_skid <= '0;
      end else begin
         if (w_load_main)           r_main <= w_entry;
         else if (w_main_from_skid) r_main <= r_skid;
         if (w_load_skid)           r_skid <= w_entry;
      end
   end

   assign imm     = r_main.imm;
   assign target  = r_main.target;
   assign doutm4  = r_main.doutm4;
   assign illegal = r_main.illegal;

endmodule
